// File: rtl/secure_mem_initiator.sv
// secure_mem_initiator
//   Command-side initiator for the secure memory's single-cycle rd_en/wr_en
//   port. Accepts one read or write command at a time (valid/ready), issues a
//   single memory strobe, captures the one-cycle read-valid pulse and returns a
//   held response with an error flag. Writes to addresses flagged in LOCK_MASK
//   (key slots) and out-of-range addresses are rejected without touching memory.
//
//   Optional feature macro: SECMEM_TIMEOUT_EN
//     defined   -> an 8-bit wait counter aborts a read with rsp_err=1 once it
//                  has spent TIMEOUT cycles in WAIT without a read-valid.
//     undefined -> no counter; WAIT waits indefinitely, TIMEOUT is ignored.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   cmd_valid/ready   command handshake; cmd_ready is high only in IDLE
//   cmd_write         1 = write, 0 = read
//   cmd_addr          word address
//   cmd_wdata         write data
//   rsp_valid/ready   response handshake; response held while rsp_ready=0
//   rsp_rdata         read data (0 for writes and errors)
//   rsp_err           locked write, out-of-range address or timeout
//   mem_rd_en/wr_en   one-cycle memory strobes, never high together
//   mem_addr/wrData   memory address / write data, 0 outside ISSUE
//   mem_rdData        memory read data
//   mem_rdData_valid  memory read-valid pulse (ignored outside WAIT)

module secure_mem_initiator #(
  parameter int                WIDTH     = 256,
  parameter int                LENGTH    = 16,
  parameter logic [LENGTH-1:0] LOCK_MASK = 16'h0404,
  parameter int                TIMEOUT   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [$clog2(LENGTH)-1:0] cmd_addr,
  input  logic [WIDTH-1:0]          cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [WIDTH-1:0]          rsp_rdata,
  output logic                      rsp_err,
  output logic                      mem_rd_en,
  output logic                      mem_wr_en,
  output logic [$clog2(LENGTH)-1:0] mem_addr,
  output logic [WIDTH-1:0]          mem_wrData,
  input  logic [WIDTH-1:0]          mem_rdData,
  input  logic                      mem_rdData_valid
);

  localparam int AW = $clog2(LENGTH);

  // The wait counter is 8 bits wide, so TIMEOUT must fit in it.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RSP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              cmd_write_q, cmd_write_d;
  logic [AW-1:0]     cmd_addr_q, cmd_addr_d;
  logic [WIDTH-1:0]  cmd_wdata_q, cmd_wdata_d;
  logic [WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              cmd_bad;

`ifdef SECMEM_TIMEOUT_EN
  logic [7:0]        wait_cnt_q, wait_cnt_d;
`endif

  // Address range is checked on the widened value so non-power-of-two
  // LENGTH values are rejected correctly; the lock bit only matters for writes.
  always_comb begin
    cmd_bad = 1'b0;
    if (32'(cmd_addr) >= 32'(LENGTH)) begin
      cmd_bad = 1'b1;
    end else if (cmd_write && LOCK_MASK[cmd_addr]) begin
      cmd_bad = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef SECMEM_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wrData  = '0;

    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_write_d = cmd_write;
          cmd_addr_d  = cmd_addr;
          cmd_wdata_d = cmd_wdata;
          if (cmd_bad) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = RSP;
          end else begin
            state_d     = ISSUE;
          end
        end
      end

      ISSUE: begin
        mem_addr   = cmd_addr_q;
        mem_wrData = cmd_wdata_q;
        if (cmd_write_q) begin
          mem_wr_en   = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          state_d     = RSP;
        end else begin
          mem_rd_en   = 1'b1;
`ifdef SECMEM_TIMEOUT_EN
          wait_cnt_d  = 8'd0;
`endif
          state_d     = WAIT;
        end
      end

      WAIT: begin
        if (mem_rdData_valid) begin
          rsp_rdata_d = mem_rdData;
          rsp_err_d   = 1'b0;
          state_d     = RSP;
        end
`ifdef SECMEM_TIMEOUT_EN
        // Abort once TIMEOUT cycles have been spent in WAIT with no valid.
        else if (wait_cnt_q + 8'd1 == 8'(TIMEOUT)) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = RSP;
        end else begin
          wait_cnt_d  = wait_cnt_q + 8'd1;
        end
`endif
      end

      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Control and response state; strobes are decoded from state_q, so they
  // drop as soon as the asynchronous reset forces IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef SECMEM_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= 8'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  // Command capture registers: only observed in ISSUE, after a load in IDLE.
  always_ff @(posedge clk) begin
    cmd_write_q <= cmd_write_d;
    cmd_addr_q  <= cmd_addr_d;
    cmd_wdata_q <= cmd_wdata_d;
  end

endmodule
